fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, consecutive unanswered request cycles before fault; used only with FETCH_TIMEOUT_EN.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  level; run fetch/execute loop while high.
REQ-005 Port pc_in  input  32  current PC value from PC register.
REQ-006 Port mem_req  output  1  instruction memory read request.
REQ-007 Port mem_addr  output  32  fetch address.
REQ-008 Port mem_ready  input  1  memory read data valid on instr_in this cycle.
REQ-009 Port ir_control  output  2  {clear, load} to instruction register; clear wins.
REQ-010 Port instr_valid  output  1  instruction register holds an instruction under execution.
REQ-011 Port exec_done  input  1  execute stage finished current instruction.
REQ-012 Port flush  input  1  discard current fetch/instruction.
REQ-013 Port pc_en  output  1  one-cycle PC advance strobe.
REQ-014 Port busy  output  1  high whenever state is not IDLE.
REQ-015 Port fetch_count  output  32  number of instruction register loads.
REQ-016 Port fault  output  1  fetch timeout, sticky.

Function
REQ-017 States: IDLE, REQ, EXEC, FAULT (FAULT only with FETCH_TIMEOUT_EN).
REQ-018 IDLE: all strobes 0; start=1 -> REQ next cycle.
REQ-019 REQ: mem_req=1, mem_addr=pc_in combinationally; pc_in is stable because pc_en=0 outside EXEC.
REQ-020 REQ with mem_ready=1: ir_control=2'b01 same cycle, fetch_count+1, -> EXEC; instruction visible in IR the next cycle.
REQ-021 REQ with mem_ready=0: hold mem_req and mem_addr, stay in REQ.
REQ-022 EXEC: instr_valid=1, mem_req=0; exec_done=1 -> pc_en=1 that cycle only, then REQ if start=1, else IDLE.
REQ-023 flush=1 in REQ or EXEC: ir_control=2'b10, mem_req=0, pc_en=0, no count increment, -> REQ next cycle. flush has priority over mem_ready and exec_done.
REQ-024 flush=1 in IDLE: ir_control=2'b10 that cycle; stay in IDLE.
REQ-025 fetch_count wraps 0xFFFF_FFFF -> 0x0000_0000.
REQ-026 ir_control=2'b00 in every cycle not covered above.

Reset
REQ-027 reset high: state IDLE, fetch_count 0, fault 0, timeout counter 0, immediately and independent of clk.
REQ-028 While reset is high: ir_control=2'b10 and every other output 0; an in-flight request is abandoned.
REQ-029 After reset deasserts: first REQ cycle is no earlier than one clk edge after start is sampled high.

Configuration
REQ-030 FETCH_TIMEOUT_EN defined: count consecutive REQ cycles with mem_ready=0, clearing on REQ entry. At TIMEOUT_CYCLES -> FAULT next edge.
REQ-031 FAULT: fault=1, mem_req=0, instr_valid=0, pc_en=0; left only by reset; flush and start are ignored.
REQ-032 FETCH_TIMEOUT_EN undefined: no counter, no FAULT state, fault tied 0, REQ waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-033 Package fetch_ctrl_pkg holds fetch_state_t enum and IR_CTRL_HOLD=2'b00, IR_CTRL_LOAD=2'b01, IR_CTRL_CLEAR=2'b10.
REQ-034 Sub-module fetch_timeout_counter, instantiated only under FETCH_TIMEOUT_EN; FSM and fetch_count are inline.

Verification
REQ-035 Reset, start=1, pc_in=0x0, mem_ready high on third REQ cycle:
- mem_req high 3 cycles, mem_addr=0x0.
- ir_control=01 in that third cycle.
- instr_valid=1 the next cycle, fetch_count=1.
REQ-036 In EXEC, exec_done=1 with start=1:
- pc_en=1 for exactly one cycle.
- Next cycle mem_req=1 with mem_addr=0x4 (PC updated).
REQ-037 In REQ, flush=1 and mem_ready=1 same cycle:
- ir_control=10, fetch_count unchanged.
- State REQ next cycle.
REQ-038 reset asserted mid-REQ between edges:
- mem_req drops and ir_control=10 immediately.
- busy=0, fetch_count=0.
REQ-039 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0:
- fault=1 after the 4th REQ cycle's edge, mem_req=0.
- fault stays 1 through flush and start toggles until reset.
REQ-040 In EXEC, exec_done=1 with start=0:
- pc_en pulses once.
- Next cycle busy=0, mem_req=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and IR control codes for the fetch controller
// FAULT state exists only when FETCH_TIMEOUT_EN is defined.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
`ifdef FETCH_TIMEOUT_EN
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_EXEC  = 2'd2
`endif
  } fetch_state_t;

  localparam logic [1:0] IR_CTRL_HOLD  = 2'b00;
  localparam logic [1:0] IR_CTRL_LOAD  = 2'b01;
  localparam logic [1:0] IR_CTRL_CLEAR = 2'b10;

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts consecutive unanswered fetch request cycles
// Used by fetch_controller only when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // expired fires on the cycle that would complete the TIMEOUT_CYCLES-th miss
  assign expired = tick && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch/execute sequencing FSM with fetch counter
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
import fetch_ctrl_pkg::*;

module fetch_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  output logic [1:0]  ir_control,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        flush,
  output logic        pc_en,
  output logic        busy,
  output logic [31:0] fetch_count,
  output logic        fault
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_t state, state_n;
  logic         count_en;
  logic         to_expired;

`ifdef FETCH_TIMEOUT_EN
  logic to_tick;
  logic to_clear;

  // a flush in REQ re-enters REQ, so it restarts the miss count
  assign to_tick  = (state == ST_REQ) && !flush && !mem_ready;
  assign to_clear = (state != ST_REQ) || flush;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .tick    (to_tick),
    .expired (to_expired)
  );

  assign fault = (state == ST_FAULT) && !reset;
`else
  assign to_expired = 1'b0;
  assign fault      = 1'b0;
`endif

  assign busy = (state != ST_IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      if (count_en) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    ir_control  = IR_CTRL_HOLD;
    instr_valid = 1'b0;
    pc_en       = 1'b0;
    count_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (flush) begin
          ir_control = IR_CTRL_CLEAR;
        end else if (start) begin
          state_n = ST_REQ;
        end
      end

      ST_REQ: begin
        if (flush) begin
          ir_control = IR_CTRL_CLEAR;
        end else begin
          mem_req  = 1'b1;
          mem_addr = pc_in;
          if (mem_ready) begin
            ir_control = IR_CTRL_LOAD;
            count_en   = 1'b1;
            state_n    = ST_EXEC;
          end else if (to_expired) begin
`ifdef FETCH_TIMEOUT_EN
            state_n = ST_FAULT;
`endif
          end
        end
      end

      ST_EXEC: begin
        instr_valid = 1'b1;
        if (flush) begin
          ir_control = IR_CTRL_CLEAR;
          state_n    = ST_REQ;
        end else if (exec_done) begin
          pc_en   = 1'b1;
          state_n = start ? ST_REQ : ST_IDLE;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
`endif

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // reset overrides everything combinationally so an in-flight request drops at once
    if (reset) begin
      mem_req     = 1'b0;
      mem_addr    = '0;
      ir_control  = IR_CTRL_CLEAR;
      instr_valid = 1'b0;
      pc_en       = 1'b0;
      count_en    = 1'b0;
    end
  end

endmodule
